uart_autobaud: RTL and testbench



---
 rtl/uart_autobaud.sv | 169 ++++++++++++++++
 tb/tb_uart_autobaud.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud.sv
// Auto-baud sequencer: measures a 0x55 sync character on i_rx and publishes its bit period (cycles-1).
// o_done/o_error pulse 2 cycles after the stop-bit hold; i_abort cancels at once with no pulse.
module uart_autobaud #(
  parameter logic [31:0] DEFAULT_BIT_LENGTH = 32'd867,
  parameter int unsigned MIN_BIT_CYCLES     = 8,
  parameter int unsigned MAX_BIT_CYCLES     = 1048576,
  parameter int unsigned IDLE_CYCLES        = 1024
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_rx,
  output logic [31:0] o_bit_length,
  output logic        o_busy,
  output logic        o_rx_block,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IDLE, S_WAIT_START, S_MEASURE,
    S_CHECK_STOP, S_STOP_HOLD, S_DONE, S_ERROR
  } state_e;

  localparam logic [31:0] MAX_C  = 32'(MAX_BIT_CYCLES);
  localparam logic [31:0] IDLE_C = 32'(IDLE_CYCLES);
  localparam logic [34:0] MIN_T8 = 35'(MIN_BIT_CYCLES) << 3;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [31:0] cnt_q, cnt_d, interval_q, interval_d;
  logic [31:0] w0_q, w0_d, t8_q, t8_d, len_q, len_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic        w0_vld_q, w0_vld_d, done_q, done_d, error_q, error_d;
  logic        rise, fall;
  logic [31:0] cnt_inc, int_inc;
  logic [34:0] t8_new, w0_x8, w0_diff, stop_lo, stop_hi, int_ext;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign rise    = ~rx_prev_q & rx_sync_q;
  assign fall    = rx_prev_q & ~rx_sync_q;
  // Incremented values count cycles since the reference edge, so T8 is exactly 8 bit times.
  assign cnt_inc = sat_inc(cnt_q);
  assign int_inc = sat_inc(interval_q);
  assign t8_new  = {3'b000, cnt_inc};
  assign w0_x8   = {w0_q, 3'b000};
  assign w0_diff = (w0_x8 >= t8_new) ? (w0_x8 - t8_new) : (t8_new - w0_x8);
  assign stop_lo = {3'b000, t8_q} >> 4;
  assign stop_hi = ({3'b000, t8_q} + {2'b00, t8_q, 1'b0}) >> 4;
  assign int_ext = {3'b000, int_inc};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    interval_d = interval_q;
    fcnt_d     = fcnt_q;
    w0_d       = w0_q;
    w0_vld_d   = w0_vld_q;
    t8_d       = t8_q;
    len_d      = len_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_WAIT_IDLE;
          cnt_d   = '0;
        end
      end
      S_WAIT_IDLE: begin
        if (cnt_q == IDLE_C) state_d = S_WAIT_START;
        else                 cnt_d   = rx_sync_q ? cnt_inc : '0;
      end
      S_WAIT_START: begin
        if (fall) begin
          state_d    = S_MEASURE;
          cnt_d      = '0;
          interval_d = '0;
          fcnt_d     = '0;
          w0_vld_d   = 1'b0;
        end
      end
      S_MEASURE: begin
        cnt_d      = cnt_inc;
        interval_d = (rise || fall) ? '0 : int_inc;
        if (rise && !w0_vld_q) begin
          w0_d     = cnt_inc;
          w0_vld_d = 1'b1;
        end
        if (fall) fcnt_d = fcnt_q + 3'd1;
        if (int_inc > MAX_C) begin
          state_d = S_ERROR;
        end else if (fall && fcnt_q == 3'd3) begin
          t8_d    = cnt_inc;
          state_d = (t8_new < MIN_T8 || w0_diff > (t8_new >> 2)) ? S_ERROR : S_CHECK_STOP;
        end
      end
      S_CHECK_STOP: begin
        interval_d = rise ? '0 : int_inc;
        if (int_inc > MAX_C) state_d = S_ERROR;
        else if (rise)       state_d = (int_ext < stop_lo || int_ext > stop_hi) ? S_ERROR : S_STOP_HOLD;
      end
      S_STOP_HOLD: begin
        interval_d = int_inc;
        if (!rx_sync_q)             state_d = S_ERROR;
        else if (int_ext >= stop_lo) state_d = S_DONE;
      end
      S_DONE: begin
        len_d   = 32'(({3'b000, t8_q} + 35'd4) >> 3) - 32'd1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_abort) begin
      state_d = S_IDLE;
      len_d   = len_q;
      done_d  = 1'b0;
      error_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q    <= S_IDLE;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      cnt_q      <= '0;
      interval_q <= '0;
      fcnt_q     <= '0;
      w0_q       <= '0;
      w0_vld_q   <= 1'b0;
      t8_q       <= '0;
      len_q      <= DEFAULT_BIT_LENGTH;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= i_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      cnt_q      <= cnt_d;
      interval_q <= interval_d;
      fcnt_q     <= fcnt_d;
      w0_q       <= w0_d;
      w0_vld_q   <= w0_vld_d;
      t8_q       <= t8_d;
      len_q      <= len_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign o_bit_length = len_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_rx_block   = o_busy;
  assign o_done       = done_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Bench for uart_autobaud: waveforms described as edge-time lists, outcomes predicted from the edge timing rules.
module tb_uart_autobaud;

  logic        clk = 1'b0;
  logic        nrst, rx, start_a, start_m, abort;
  logic [31:0] a_len, m_len;
  logic        a_busy, a_rxblk, a_done, a_error;
  logic        m_busy, m_rxblk, m_done, m_error;

  int n_cmp = 0;
  int n_bad = 0;
  int a_done_n = 0, a_err_n = 0, m_done_n = 0, m_err_n = 0;
  logic a_busy_at_done = 1'b1;
  logic [31:0] exp_len_a = 32'd867;
  logic [31:0] exp_len_m = 32'd867;

  always #5 clk = ~clk;

  uart_autobaud dut_a (
    .i_clk(clk), .i_nrst(nrst), .i_start(start_a), .i_abort(abort), .i_rx(rx),
    .o_bit_length(a_len), .o_busy(a_busy), .o_rx_block(a_rxblk),
    .o_done(a_done), .o_error(a_error)
  );

  uart_autobaud #(.MAX_BIT_CYCLES(1000)) dut_m (
    .i_clk(clk), .i_nrst(nrst), .i_start(start_m), .i_abort(abort), .i_rx(rx),
    .o_bit_length(m_len), .o_busy(m_busy), .o_rx_block(m_rxblk),
    .o_done(m_done), .o_error(m_error)
  );

  always @(negedge clk) begin
    if (a_done) begin
      a_done_n       <= a_done_n + 1;
      a_busy_at_done <= a_busy;
    end
    if (a_error) a_err_n  <= a_err_n + 1;
    if (m_done)  m_done_n <= m_done_n + 1;
    if (m_error) m_err_n  <= m_err_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Edge list: e[0] is the start-bit fall at time 0, then alternating rise/fall; line high after the last.
  // Returns 1 for a successful measurement (t8 = 8-bit-time span), 2 for an error.
  function automatic int ref_outcome(input int e[$], input int maxc, output int t8);
    int w0, nf, i, h, g;
    longint dev;
    t8 = 0; w0 = -1; nf = 0;
    for (i = 1; i < e.size(); i++) begin
      if (e[i] - e[i-1] > maxc) return 2;
      if (i % 2 == 1) begin
        if (w0 < 0) w0 = e[i];
      end else begin
        nf++;
        if (nf == 4) begin
          t8 = e[i];
          break;
        end
      end
    end
    if (nf < 4) return 2;
    if (t8 < 8 * 8) return 2;
    dev = 8 * longint'(w0) - longint'(t8);
    if (dev < 0) dev = -dev;
    if (dev > longint'(t8 / 4)) return 2;
    if (i + 1 >= e.size()) return 2;
    g = e[i+1] - t8;
    if (g > maxc) return 2;
    if (g < t8 / 16 || g > (3 * t8) / 16) return 2;
    h = t8 / 16;
    if (i + 2 < e.size() && e[i+2] - e[i+1] <= h) return 2;
    return 1;
  endfunction

  task automatic run_trial(input string tag, input int e[$], input int idle, input bit use_m, input bit poke);
    int outcome, t8, seg, d0, r0;
    logic [31:0] exp_len;
    outcome = ref_outcome(e, use_m ? 1000 : 1048576, t8);
    d0 = use_m ? m_done_n : a_done_n;
    r0 = use_m ? m_err_n  : a_err_n;
    @(negedge clk);
    if (use_m) start_m = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_m = 1'b0;
    rx = 1'b1;
    repeat (idle) @(negedge clk);
    for (int i = 0; i < e.size(); i++) begin
      rx  = (i % 2 == 1);
      seg = (i + 1 < e.size()) ? e[i+1] - e[i] : 0;
      if (poke && i == 3) begin
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        seg--;
      end
      repeat (seg) @(negedge clk);
    end
    for (int k = 0; k < 4000; k++) begin
      if (!(use_m ? m_busy : a_busy)) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    if (outcome == 1) begin
      exp_len = 32'(((t8 + 4) >> 3) - 1);
      if (use_m) exp_len_m = exp_len; else exp_len_a = exp_len;
    end
    check($sformatf("%s/busy_end", tag), use_m ? m_busy : a_busy, 0);
    check($sformatf("%s/done_cnt", tag), (use_m ? m_done_n : a_done_n) - d0, (outcome == 1) ? 1 : 0);
    check($sformatf("%s/err_cnt", tag),  (use_m ? m_err_n  : a_err_n)  - r0, (outcome == 2) ? 1 : 0);
    check($sformatf("%s/len", tag), use_m ? m_len : a_len, use_m ? exp_len_m : exp_len_a);
    if (outcome == 1 && !use_m) check($sformatf("%s/busy_at_done", tag), a_busy_at_done, 0);
  endtask

  function automatic void sync55(output int e[$], input int p);
    e = {};
    for (int k = 0; k < 10; k++) e.push_back(k * p);
  endfunction

  initial begin
    int e[$];
    int d0, r0, p, mode, r, g;
    nrst = 1'b0; rx = 1'b1; start_a = 1'b0; start_m = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("reset/len", a_len, 867);
    check("reset/busy", a_busy, 0);
    check("reset/rx_block", a_rxblk, 0);
    check("reset/done", a_done, 0);
    check("reset/error", a_error, 0);

    sync55(e, 100);
    run_trial("ideal100", e, 1100, 1'b0, 1'b1);

    e = {0};
    for (int k = 1; k < 10; k++) e.push_back(k * 1000 + int'($urandom_range(0, 6)) - 3);
    run_trial("jitter1000", e, 1100, 1'b0, 1'b0);

    e = {0};
    for (int k = 1; k < 10; k++) e.push_back(150 + (k - 1) * 100);
    run_trial("wide_start", e, 1100, 1'b0, 1'b0);

    e = {0, 900};
    run_trial("max_timeout", e, 1100, 1'b1, 1'b0);

    // Start and abort together in IDLE must leave the block idle.
    @(negedge clk);
    start_a = 1'b1; abort = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort = 1'b0;
    check("start_abort/busy", a_busy, 0);

    // Line held low: stuck in the idle wait until aborted.
    d0 = a_done_n; r0 = a_err_n;
    rx = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5000) @(negedge clk);
    check("low_line/busy", a_busy, 1);
    check("low_line/rx_block", a_rxblk, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort/busy", a_busy, 0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("abort/done_cnt", a_done_n - d0, 0);
    check("abort/err_cnt", a_err_n - r0, 0);
    check("abort/len", a_len, exp_len_a);

    sync55(e, 64);
    run_trial("after_abort64", e, 1100, 1'b0, 1'b0);

    // Reset in the middle of a measurement.
    d0 = a_done_n; r0 = a_err_n;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (1100) @(negedge clk);
    rx = 1'b0; repeat (100) @(negedge clk);
    rx = 1'b1; repeat (100) @(negedge clk);
    rx = 1'b0; repeat (50) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("mid_reset/len", a_len, 867);
    check("mid_reset/busy", a_busy, 0);
    @(negedge clk);
    nrst = 1'b1;
    rx = 1'b1;
    exp_len_a = 32'd867;
    exp_len_m = 32'd867;
    repeat (3000) @(negedge clk);
    check("mid_reset/done_cnt", a_done_n - d0, 0);
    check("mid_reset/err_cnt", a_err_n - r0, 0);
    check("mid_reset/busy_after", a_busy, 0);

    for (int t = 0; t < 10; t++) begin
      p = $urandom_range(16, 120);
      mode = $urandom_range(0, 3);
      e = {0};
      for (int k = 1; k < 10; k++) e.push_back(k * p + int'($urandom_range(0, 4)) - 2);
      case (mode)
        1: begin r = $urandom_range(5, 18); e[1] = p * r / 10; end
        2: begin g = $urandom_range(1, p); e.push_back(e[9] + g); e.push_back(e[9] + g + p); end
        3: begin r = $urandom_range(3, 20); e[9] = e[8] + p * r / 10; end
        default: ;
      endcase
      run_trial($sformatf("rand%0d_m%0d_p%0d", t, mode, p), e, $urandom_range(1030, 1200), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
